// File: rtl/proc_pkg.sv
// Shared processor definitions used by the fetch/decode stage and the execution unit:
// opcode values, instruction field bit positions and the fetch/decode FSM state type.
package proc_pkg;

    localparam logic [3:0] OP_ADD   = 4'h1;
    localparam logic [3:0] OP_LOAD  = 4'h4;
    localparam logic [3:0] OP_STORE = 4'h5;
    localparam logic [3:0] OP_HALT  = 4'hF;

    // Instruction layout: [15:12] opcode, [11:9] dest, [8:6] srcA, [5:3] srcB, [2:0] reserved
    localparam int OPC_MSB  = 15;
    localparam int OPC_LSB  = 12;
    localparam int DEST_MSB = 11;
    localparam int DEST_LSB = 9;
    localparam int SRCA_MSB = 8;
    localparam int SRCA_LSB = 6;
    localparam int SRCB_MSB = 5;
    localparam int SRCB_LSB = 3;
    localparam int RSVD_MSB = 2;

    typedef enum logic [1:0] {
        IDLE,
        RUN,
        DRAIN,
        HALT
    } ifd_state_t;

    // True when the instruction word carries the HALT opcode
    function automatic logic isHaltInstr(input logic [15:0] instr);
        return instr[OPC_MSB:OPC_LSB] == OP_HALT;
    endfunction

endpackage

// File: rtl/instr_hold_buf.sv
// One-entry skid register for the fetch/decode stage. Catches a ROM response that
// arrives while the decoded outputs are stalled, together with the PC it was fetched from.
// A new push takes priority over a pop so an entry can be replaced in a single cycle.
module instr_hold_buf #(
    parameter int PC_W    = 8,
    parameter int INSTR_W = 16
) (
    input  logic               clk,
    input  logic               reset,
    input  logic               flush,
    input  logic               push,
    input  logic               pop,
    input  logic [INSTR_W-1:0] pushInstr,
    input  logic [PC_W-1:0]    pushPc,
    output logic               holdValid,
    output logic [INSTR_W-1:0] holdInstr,
    output logic [PC_W-1:0]    holdPc
);

    // Capture, replace, or release the single buffered instruction
    always_ff @(posedge clk or posedge reset) begin
        if (reset) begin
            holdValid <= 1'b0;
            holdInstr <= '0;
            holdPc    <= '0;
        end else if (flush) begin
            holdValid <= 1'b0;
        end else if (push) begin
            holdValid <= 1'b1;
            holdInstr <= pushInstr;
            holdPc    <= pushPc;
        end else if (pop) begin
            holdValid <= 1'b0;
        end
    end

endmodule

// File: rtl/instr_fetch_decode.sv
// Fetch/decode front end feeding the execution unit. Issues reads to a synchronous
// instruction ROM (one cycle latency), decodes the returned word into register fields
// and holds them stable under downstream stall, using a one-entry skid buffer so no
// instruction is lost or duplicated. A HALT opcode drains the stage and parks it.
// Optional feature macro: IFD_REDIRECT_EN adds redirect_valid/redirect_pc for PC redirects.
module instr_fetch_decode #(
    parameter int              PC_W     = 8,
    parameter int              INSTR_W  = 16,
    parameter logic [PC_W-1:0] RESET_PC = '0
) (
    input  logic               clk,
    input  logic               reset,
    output logic               imem_req,
    output logic [PC_W-1:0]    imem_addr,
    input  logic [INSTR_W-1:0] imem_data,
    input  logic               stall,
`ifdef IFD_REDIRECT_EN
    input  logic               redirect_valid,
    input  logic [PC_W-1:0]    redirect_pc,
`endif
    output logic               dec_valid,
    output logic [3:0]         opcode,
    output logic [2:0]         dest_reg,
    output logic [2:0]         opAAdr,
    output logic [2:0]         opBAder,
    output logic [PC_W-1:0]    pc_out,
    output logic               halted
);

    import proc_pkg::*;

    localparam logic [PC_W-1:0] PC_ONE = 1;

    ifd_state_t         state;
    ifd_state_t         stateNext;
    logic [PC_W-1:0]    pc;
    logic [PC_W-1:0]    inFlightPc;
    logic               inFlight;
    logic               reqIssue;
    logic               loadOut;
    logic               srcValid;
    logic [INSTR_W-1:0] srcInstr;
    logic [PC_W-1:0]    srcPc;
    logic               haltLoad;
    logic               redirectNow;
    logic [PC_W-1:0]    redirectTarget;
    logic               holdValid;
    logic [INSTR_W-1:0] holdInstr;
    logic [PC_W-1:0]    holdPc;
    logic               holdPush;
    logic               holdPop;
    logic               holdFlush;
    logic               unusedRsvdBits;

`ifdef IFD_REDIRECT_EN
    assign redirectNow    = redirect_valid && (state != HALT);
    assign redirectTarget = redirect_pc;
`else
    assign redirectNow    = 1'b0;
    assign redirectTarget = '0;
`endif

    // The buffered word always wins over the ROM bus so program order is preserved
    assign loadOut  = !dec_valid || !stall;
    assign srcValid = holdValid || inFlight;
    assign srcInstr = holdValid ? holdInstr : imem_data;
    assign srcPc    = holdValid ? holdPc : inFlightPc;
    assign haltLoad = (state == RUN) && loadOut && srcValid && isHaltInstr(srcInstr);

    assign holdFlush = redirectNow || (state != RUN);
    assign holdPush  = (state == RUN) && inFlight && (!loadOut || holdValid);
    assign holdPop   = (state == RUN) && loadOut && holdValid;

    assign imem_req  = reqIssue;
    assign imem_addr = (state == RUN) ? pc : '0;

    assign unusedRsvdBits = ^srcInstr[RSVD_MSB:0];

    instr_hold_buf #(
        .PC_W    (PC_W),
        .INSTR_W (INSTR_W)
    ) u_holdBuf (
        .clk       (clk),
        .reset     (reset),
        .flush     (holdFlush),
        .push      (holdPush),
        .pop       (holdPop),
        .pushInstr (imem_data),
        .pushPc    (inFlightPc),
        .holdValid (holdValid),
        .holdInstr (holdInstr),
        .holdPc    (holdPc)
    );

    // FSM state register
    always_ff @(posedge clk or posedge reset) begin
        if (reset) begin
            state <= IDLE;
        end else begin
            state <= stateNext;
        end
    end

    // Next-state and fetch-request decision; fetch pauses while stalled or while the buffer is occupied
    always_comb begin
        stateNext = state;
        reqIssue  = 1'b0;
        case (state)
            IDLE: begin
                stateNext = RUN;
            end
            RUN: begin
                reqIssue = !stall && !holdValid;
                if (haltLoad) begin
                    stateNext = DRAIN;
                end
            end
            DRAIN: begin
                if (dec_valid && !stall) begin
                    stateNext = HALT;
                end
            end
            HALT: begin
                stateNext = HALT;
            end
            default: begin
                stateNext = IDLE;
            end
        endcase
        if (redirectNow) begin
            stateNext = RUN;
        end
    end

    // PC sequencing and in-flight tracking; a redirect drops whatever the ROM returns next
    always_ff @(posedge clk or posedge reset) begin
        if (reset) begin
            pc         <= RESET_PC;
            inFlight   <= 1'b0;
            inFlightPc <= '0;
        end else if (redirectNow) begin
            pc       <= redirectTarget;
            inFlight <= 1'b0;
        end else begin
            inFlight <= reqIssue;
            if (reqIssue) begin
                pc         <= pc + PC_ONE;
                inFlightPc <= pc;
            end
        end
    end

    // Decoded output registers plus the sticky halted flag
    always_ff @(posedge clk or posedge reset) begin
        if (reset) begin
            dec_valid <= 1'b0;
            opcode    <= '0;
            dest_reg  <= '0;
            opAAdr    <= '0;
            opBAder   <= '0;
            pc_out    <= '0;
            halted    <= 1'b0;
        end else if (redirectNow) begin
            dec_valid <= 1'b0;
        end else if (state == RUN && loadOut) begin
            dec_valid <= srcValid;
            if (srcValid) begin
                opcode   <= srcInstr[OPC_MSB:OPC_LSB];
                dest_reg <= srcInstr[DEST_MSB:DEST_LSB];
                opAAdr   <= srcInstr[SRCA_MSB:SRCA_LSB];
                opBAder  <= srcInstr[SRCB_MSB:SRCB_LSB];
                pc_out   <= srcPc;
            end
        end else if (state == DRAIN && dec_valid && !stall) begin
            dec_valid <= 1'b0;
            halted    <= 1'b1;
        end
    end

endmodule
